// File: rtl/bop_round_if.sv
// Reaction-game round controller bus: game inputs and player-facing outputs.
// The master drives tick/start/cmd_in/btn; the controller drives the rest.
interface bop_round_if;
  logic       tick;
  logic       start;
  logic [1:0] cmd_in;
  logic [3:0] btn;
  logic [3:0] prompt;
  logic [3:0] time_left;
  logic [7:0] score;
  logic       game_over;
  logic       busy;

  modport master (
    output tick, start, cmd_in, btn,
    input  prompt, time_left, score, game_over, busy
  );

  modport slave (
    input  tick, start, cmd_in, btn,
    output prompt, time_left, score, game_over, busy
  );
endinterface

// File: rtl/bop_round_ctrl.sv
// Bop-it style round controller: prompts a button, times the response
// window, scores hits and shrinks the window as the score climbs.
module bop_round_ctrl #(
  parameter int unsigned WINDOW_INIT  = 8,
  parameter int unsigned WINDOW_MIN   = 2,
  parameter int unsigned SHRINK_EVERY = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  bop_round_if.slave  io
);

  typedef enum logic [1:0] {
    IDLE,
    PROMPT,
    RELEASE,
    OVER
  } state_e;

  localparam logic [3:0] WIN_INIT = 4'(WINDOW_INIT);
  localparam logic [3:0] WIN_MIN  = 4'(WINDOW_MIN);
  localparam logic [7:0] SH_MASK  = 8'(SHRINK_EVERY - 1);

  state_e     state_q;
  logic [3:0] s1_q, s2_q, s3_q;
  logic [1:0] cmd_q;
  logic [3:0] win_q;
  logic [3:0] tl_q;
  logic [7:0] score_q;

  logic [3:0] press;
  logic [3:0] onehot;
  logic [7:0] score_d;
  logic [3:0] win_d;
  logic       shrink;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= io.btn;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  always_comb begin
    press   = s2_q & ~s3_q;
    onehot  = 4'b0001 << cmd_q;
    score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
    shrink  = (score_d & SH_MASK) == 8'd0;
    win_d   = (win_q > WIN_MIN) ? win_q - 4'd1 : WIN_MIN;
  end

  // A hit takes priority over a same-cycle tick, so the last tick never
  // steals a correct press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      tl_q    <= '0;
      win_q   <= WIN_INIT;
      score_q <= '0;
    end else begin
      unique case (state_q)
        IDLE, OVER: begin
          if (io.start) begin
            score_q <= '0;
            win_q   <= WIN_INIT;
            tl_q    <= WIN_INIT;
            cmd_q   <= io.cmd_in;
            state_q <= PROMPT;
          end
        end
        PROMPT: begin
          if (press == onehot) begin
            score_q <= score_d;
            if (shrink) win_q <= win_d;
            state_q <= RELEASE;
          end else if (press != 4'b0000) begin
            state_q <= OVER;
          end else if (io.tick) begin
            if (tl_q == 4'd1) begin
              tl_q    <= '0;
              state_q <= OVER;
            end else begin
              tl_q <= tl_q - 4'd1;
            end
          end
        end
        RELEASE: begin
          if (s2_q == 4'b0000) begin
            cmd_q   <= io.cmd_in;
            tl_q    <= win_q;
            state_q <= PROMPT;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign io.prompt    = (state_q == PROMPT) ? onehot : 4'b0000;
  assign io.time_left = tl_q;
  assign io.score     = score_q;
  assign io.game_over = (state_q == OVER);
  assign io.busy      = (state_q == PROMPT) || (state_q == RELEASE);

endmodule

// File: tb/tb_bop_round_ctrl.sv
// Random and directed bench for bop_round_ctrl against a game-rule model.
// The model is compared with the DUT on every falling clock edge.
module tb_bop_round_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  bop_round_if io ();

  bop_round_ctrl #(
    .WINDOW_INIT (8),
    .WINDOW_MIN  (2),
    .SHRINK_EVERY(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .io   (io)
  );

  // ---------------- behavioural model ----------------
  int         m_score = 0;
  int         m_tl    = 0;
  logic [1:0] m_cmd   = 2'd0;
  bit         m_prompting = 0;
  bit         m_releasing = 0;
  bit         m_over      = 0;
  logic [3:0] h1 = 0, h2 = 0, h3 = 0;

  function automatic int win_of(int s);
    int w;
    w = 8 - s / 4;
    return (w < 2) ? 2 : w;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic [3:0] p;
    logic [3:0] syn;
    logic [3:0] want;
    if (!rst_n) begin
      m_score = 0; m_tl = 0; m_cmd = 0;
      m_prompting = 0; m_releasing = 0; m_over = 0;
      h1 = 0; h2 = 0; h3 = 0;
    end else begin
      // a press is a button seen high two edges ago but low three edges ago
      p   = h2 & ~h3;
      syn = h2;
      h3 = h2; h2 = h1; h1 = io.btn;
      want = 4'b0001 << m_cmd;
      if (m_prompting) begin
        if (p == want) begin
          if (m_score < 255) m_score++;
          m_prompting = 0; m_releasing = 1;
        end else if (p != 0) begin
          m_prompting = 0; m_over = 1;
        end else if (io.tick) begin
          m_tl--;
          if (m_tl == 0) begin
            m_prompting = 0; m_over = 1;
          end
        end
      end else if (m_releasing) begin
        if (syn == 0) begin
          m_cmd = io.cmd_in;
          m_tl  = win_of(m_score);
          m_releasing = 0; m_prompting = 1;
        end
      end else if (io.start) begin
        m_score = 0; m_tl = 8; m_cmd = io.cmd_in;
        m_over = 0; m_prompting = 1;
      end
    end
  end

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("prompt", io.prompt, m_prompting ? (4'b0001 << m_cmd) : 4'b0000);
    chk("time_left", io.time_left, m_tl);
    chk("score", io.score, m_score);
    chk("game_over", io.game_over, m_over);
    chk("busy", io.busy, m_prompting || m_releasing);
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_start(logic [1:0] c);
    io.start  = 1'b1;
    io.cmd_in = c;
    @(negedge clk);
    io.start = 1'b0;
  endtask

  task automatic wait_prompt();
    int n = 0;
    while (io.prompt == 4'b0000 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("prompt_wait_bound", int'(n < 20), 1);
  endtask

  task automatic hit();
    io.btn = 4'b0001 << m_cmd;
    repeat (3) @(negedge clk);
    io.btn    = 4'b0000;
    io.cmd_in = 2'($urandom);
    wait_prompt();
  endtask

  task automatic tick_once();
    io.tick = 1'b1;
    @(negedge clk);
    io.tick = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int r;
    rst_n     = 1'b0;
    io.tick   = 1'b0;
    io.start  = 1'b0;
    io.cmd_in = 2'd0;
    io.btn    = 4'b0000;
    repeat (3) @(negedge clk);
    chk("rst_prompt", io.prompt, 0);
    chk("rst_time_left", io.time_left, 0);
    chk("rst_score", io.score, 0);
    chk("rst_busy", io.busy, 0);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // first hit and release
    do_start(2'd2);
    chk("start_prompt", io.prompt, 4'b0100);
    chk("start_tl", io.time_left, 8);
    io.btn = 4'b0100;
    repeat (2) @(negedge clk);
    chk("hit_latency_2", io.score, 0);
    @(negedge clk);
    chk("hit_latency_3", io.score, 1);
    chk("release_prompt", io.prompt, 0);
    chk("release_busy", io.busy, 1);
    io.btn    = 4'b0000;
    io.cmd_in = 2'd1;
    wait_prompt();
    chk("reload_prompt", io.prompt, 4'b0010);
    chk("reload_tl", io.time_left, 8);

    // wrong button, then two buttons at once
    io.btn = 4'b1000;
    repeat (3) @(negedge clk);
    chk("miss_over", io.game_over, 1);
    chk("miss_score", io.score, 1);
    io.btn = 4'b0000;
    repeat (3) @(negedge clk);
    do_start(2'd0);
    chk("p0_prompt", io.prompt, 4'b0001);
    chk("p0_score", io.score, 0);
    io.btn = 4'b0011;
    repeat (3) @(negedge clk);
    chk("multi_over", io.game_over, 1);
    io.btn = 4'b0000;
    repeat (3) @(negedge clk);

    // timeout
    do_start(2'd3);
    for (int i = 1; i <= 8; i++) begin
      tick_once();
      chk("to_tl", io.time_left, 8 - i);
      chk("to_over", io.game_over, int'(i == 8));
    end
    chk("to_score", io.score, 0);

    // window shrink over 24 hits
    do_start(2'($urandom));
    for (int h = 1; h <= 24; h++) begin
      hit();
      chk("shr_score", io.score, h);
      chk("shr_tl", io.time_left, win_of(h));
      if (h == 4)  chk("shr_tl_h4", io.time_left, 7);
      if (h == 20) chk("shr_tl_h20", io.time_left, 3);
      if (h == 24) chk("shr_tl_h24", io.time_left, 2);
    end

    // correct press lands on the last tick
    tick_once();
    chk("edge_tl1", io.time_left, 1);
    io.btn = 4'b0001 << m_cmd;
    repeat (2) @(negedge clk);
    io.tick = 1'b1;
    @(negedge clk);
    io.tick = 1'b0;
    chk("edge_score", io.score, 25);
    chk("edge_over", io.game_over, 0);
    io.btn = 4'b0000;
    wait_prompt();

    // start is ignored mid-game
    io.start = 1'b1;
    @(negedge clk);
    io.start = 1'b0;
    chk("ign_score", io.score, 25);
    chk("ign_tl", io.time_left, 2);

    // reset mid-game at score 5, with a button held through reset
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    @(negedge clk);
    do_start(2'($urandom));
    repeat (5) hit();
    chk("pre_rst_score", io.score, 5);
    io.btn = 4'b0001 << m_cmd;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_prompt", io.prompt, 0);
    chk("arst_tl", io.time_left, 0);
    chk("arst_score", io.score, 0);
    chk("arst_over", io.game_over, 0);
    chk("arst_busy", io.busy, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("held_idle", io.busy, 0);
    io.btn = 4'b0000;
    repeat (3) @(negedge clk);
    do_start(2'd1);
    chk("fresh_score", io.score, 0);
    chk("fresh_tl", io.time_left, 8);
    chk("fresh_prompt", io.prompt, 4'b0010);

    // random play
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      r = $urandom_range(0, 99);
      io.tick   = ($urandom_range(0, 3) == 0);
      io.start  = ($urandom_range(0, 29) == 0);
      io.cmd_in = 2'($urandom);
      if (r < 25)      io.btn = 4'b0000;
      else if (r < 35) io.btn = 4'b0001 << m_cmd;
      else if (r < 38) io.btn = 4'($urandom);
      if ($urandom_range(0, 699) == 0) begin
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
    end
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
